// File: rtl/min_distance_sequencer.sv
// -----------------------------------------------------------------------------
// min_distance_sequencer
//
// Sequential minimum finder. Candidate distances arrive one per handshake. Each
// later candidate is compared against the running minimum with one 2-bit
// compare slice, which is reused MSB-first over W/2 cycles. The block keeps the
// smallest distance and its zero-based arrival index. It presents the winner
// once the candidate marked last has been resolved.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   candidate present
//   in_ready   block accepts a candidate this cycle (IDLE only)
//   in_dist    candidate distance, unsigned, W bits
//   in_last    candidate is the final one of the set
//   res_valid  result available (DONE)
//   res_ready  result consumed
//   res_dist   minimum distance of the set
//   res_idx    arrival index of the minimum, wraps modulo 2^IDX_W
//   busy       high in any state other than IDLE
//
// Configuration macro:
//   MIN_DISTANCE_SEQ_EARLY_EXIT_EN - when defined, the compare ends on the
//   first slice that differs, because the outcome is already fixed at that
//   point. Results are the same as the fixed-length compare; only latency
//   changes.
// -----------------------------------------------------------------------------
module min_distance_sequencer #(
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_dist,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_dist,
    output logic [IDX_W-1:0] res_idx,
    output logic             busy
);

    localparam int SLICES = W / 2;
    localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [W-1:0]     best_dist_q,  best_dist_d;
    logic [IDX_W-1:0] best_idx_q,   best_idx_d;
    logic             best_valid_q, best_valid_d;
    logic [W-1:0]     cand_dist_q,  cand_dist_d;
    logic [IDX_W-1:0] cand_idx_q,   cand_idx_d;
    logic             cand_last_q,  cand_last_d;
    logic [IDX_W-1:0] cnt_q,        cnt_d;
    logic             eq_q,         eq_d;
    logic             lt_q,         lt_d;
    logic [SL_W-1:0]  sl_q,         sl_d;

    logic [1:0] a_sl;
    logic [1:0] b_sl;
    logic       lt_next;
    logic       eq_next;
    logic       cmp_term;

    // Select the current 2-bit slice of candidate and best with constant
    // indices so every bit of both operands feeds the mux.
    always_comb begin
        a_sl = 2'b00;
        b_sl = 2'b00;
        for (int s = 0; s < SLICES; s++) begin
            if (sl_q == SL_W'(s)) begin
                a_sl = cand_dist_q[2*s +: 2];
                b_sl = best_dist_q[2*s +: 2];
            end
        end
    end

    // One MSB-first compare step: lt latches once a higher slice decided
    // candidate < best; eq stays high only while all slices so far matched.
    always_comb begin
        lt_next = (~a_sl[1] & b_sl[1] & eq_q)
                | (~a_sl[0] & b_sl[0] & (a_sl[1] ~^ b_sl[1]) & eq_q)
                | lt_q;
        eq_next = eq_q & (a_sl[1] ~^ b_sl[1]) & (a_sl[0] ~^ b_sl[0]);
`ifdef MIN_DISTANCE_SEQ_EARLY_EXIT_EN
        cmp_term = (sl_q == '0) || !eq_next;
`else
        cmp_term = (sl_q == '0);
`endif
    end

    always_comb begin
        state_d      = state_q;
        best_dist_d  = best_dist_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;
        cand_dist_d  = cand_dist_q;
        cand_idx_d   = cand_idx_q;
        cand_last_d  = cand_last_q;
        cnt_d        = cnt_q;
        eq_d         = eq_q;
        lt_d         = lt_q;
        sl_d         = sl_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!best_valid_q) begin
                        // First candidate of a set becomes the minimum directly.
                        best_dist_d  = in_dist;
                        best_idx_d   = cnt_q;
                        best_valid_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cand_dist_d = in_dist;
                        cand_idx_d  = cnt_q;
                        cand_last_d = in_last;
                        eq_d        = 1'b1;
                        lt_d        = 1'b0;
                        sl_d        = SL_W'(SLICES - 1);
                        state_d     = S_CMP;
                    end
                end
            end

            S_CMP: begin
                eq_d = eq_next;
                lt_d = lt_next;
                sl_d = sl_q - 1'b1;
                if (cmp_term) begin
                    // Strict less-than only: ties keep the earlier candidate.
                    if (lt_next) begin
                        best_dist_d = cand_dist_q;
                        best_idx_d  = cand_idx_q;
                    end
                    state_d = cand_last_q ? S_DONE : S_IDLE;
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    best_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            best_dist_q  <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            cand_dist_q  <= '0;
            cand_idx_q   <= '0;
            cand_last_q  <= 1'b0;
            cnt_q        <= '0;
            eq_q         <= 1'b0;
            lt_q         <= 1'b0;
            sl_q         <= '0;
        end else begin
            state_q      <= state_d;
            best_dist_q  <= best_dist_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
            cand_dist_q  <= cand_dist_d;
            cand_idx_q   <= cand_idx_d;
            cand_last_q  <= cand_last_d;
            cnt_q        <= cnt_d;
            eq_q         <= eq_d;
            lt_q         <= lt_d;
            sl_q         <= sl_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_dist  = (state_q == S_DONE) ? best_dist_q : '0;
    assign res_idx   = (state_q == S_DONE) ? best_idx_q  : '0;

endmodule

// File: tb/tb_min_distance_sequencer.sv
// -----------------------------------------------------------------------------
// tb_min_distance_sequencer
//
// Self-checking bench for min_distance_sequencer (W=8, IDX_W=4). Directed sets
// and random sets are checked against a reference built from plain arithmetic:
// the minimum value with the earliest index on ties, the index taken modulo 16,
// and the number of compare cycles for each later candidate.
// -----------------------------------------------------------------------------
module tb_min_distance_sequencer;

    localparam int W     = 8;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_dist;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_dist;
    logic [IDX_W-1:0] res_idx;
    logic             busy;

    int errors;
    int checks;
    int dq[$];

    min_distance_sequencer #(.W(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dist   (in_dist),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_dist  (res_dist),
        .res_idx   (res_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected number of cycles in_ready is low for a non-first candidate.
    function automatic int exp_cmp_cycles(input int cand, input int best);
        int n;
        n = W / 2;
`ifdef MIN_DISTANCE_SEQ_EARLY_EXIT_EN
        n = 0;
        for (int s = W / 2 - 1; s >= 0; s--) begin
            n++;
            if (((cand >> (2 * s)) & 3) != ((best >> (2 * s)) & 3)) break;
        end
`endif
        return n;
    endfunction

    // Offer one candidate, return how many cycles in_ready stayed low before
    // IDLE or DONE was reached. Called and returns at a negedge.
    task automatic send(input logic [W-1:0] d, input logic last, output int low);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_dist  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_dist  = W'($urandom);
        low = 0;
        while (!in_ready && !res_valid && low < 50) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic collect(input int exp_dist, input int exp_idx, input int hold);
        int waited;
        waited = 0;
        while (!res_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("res_latency", waited, 0);
        chk("res_dist", int'(res_dist), exp_dist);
        chk("res_idx", int'(res_idx), exp_idx);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_dist", int'(res_dist), exp_dist);
            chk("hold_idx", int'(res_idx), exp_idx);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_res_valid", int'(res_valid), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic run_set(input int hold);
        int best;
        int bidx;
        int low;
        int exp_low;
        best = 0;
        bidx = 0;
        for (int k = 0; k < dq.size(); k++) begin
            exp_low = (k == 0) ? 0 : exp_cmp_cycles(dq[k], best);
            send(W'(dq[k]), k == dq.size() - 1, low);
            chk("in_ready_low", low, exp_low);
            if (k == 0 || dq[k] < best) begin
                best = dq[k];
                bidx = k % (1 << IDX_W);
            end
        end
        collect(best, bidx, hold);
    endtask

    initial begin
        int low;
        int len;
        int mask;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_dist", int'(res_dist), 0);
        chk("rst_res_idx", int'(res_idx), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sets; the first one also holds the result for 10 cycles.
        dq = '{8'h5A};             run_set(10);
        dq = '{8'h40, 8'h3F, 8'h80}; run_set(0);
        dq = '{8'h22, 8'h22};      run_set(0);
        dq = '{8'hFF, 8'h00};      run_set(0);
        dq = '{8'h90, 8'h10};      run_set(0);
        dq = '{8'h90, 8'h91};      run_set(0);

        // Reset in the middle of the second compare cycle.
        send(8'h40, 1'b0, low);
        in_valid = 1'b1;
        in_dist  = 8'h41;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_res_dist", int'(res_dist), 0);
        chk("mid_rst_res_idx", int'(res_idx), 0);
        chk("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dq = '{8'h07};             run_set(0);

        // Random sets, some long enough to wrap the index, some with a narrow
        // value range to provoke ties.
        for (int t = 0; t < 40; t++) begin
            len  = $urandom_range(1, 22);
            mask = ($urandom_range(0, 2) == 0) ? 8'h03 : 8'hFF;
            dq.delete();
            for (int i = 0; i < len; i++) dq.push_back(int'($urandom) & mask);
            run_set($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
